piso_shift_tx: RTL

Parallel-in, serial-out transmitter for the memory-elements library. It is the reading end of the parallel-load 4-bit register family: it captures a WIDTH-bit word on a load handshake and streams it out one bit per enabled clock, with valid, last and done framing. A downstream serial-in/parallel-out receiver uses these flags to reassemble the word.

---
 rtl/piso_shift_tx_if.sv | 26 ++
 rtl/piso_shreg.sv | 47 ++++
 rtl/piso_shift_tx.sv | 115 +++++++++++
 3 files changed

// File: rtl/piso_shift_tx_if.sv
// Parallel-in / serial-out transmitter bus: parallel load handshake on one
// side, framed serial stream on the other.
interface piso_shift_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in;
    logic             load;
    logic             en;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             last;
    logic             done;

    // Producer of words / consumer of the serial stream.
    modport master (
        output in, load, en,
        input  ready, sout, sout_valid, last, done
    );

    // The transmitter itself.
    modport slave (
        input  in, load, en,
        output ready, sout, sout_valid, last, done
    );
endinterface

// File: rtl/piso_shreg.sv
// WIDTH-bit shift register with parallel load and zero-filled shift toward
// the output end. Also reports the bit that will sit at the output end after
// the next shift, so the owner can register sout without a combinational path.
module piso_shreg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             next_bit
);
    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shifted;

    // Build the shifted image bit by bit; the far end fills with zero.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_fill
                assign shifted[gi] = 1'b0;
            end else begin : g_move
                assign shifted[gi] = shreg_reg[gi-1];
            end
        end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_fill
                assign shifted[gi] = 1'b0;
            end else begin : g_move
                assign shifted[gi] = shreg_reg[gi+1];
            end
        end
    end

    assign next_bit = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];

    // Load has priority over shift; the two are never requested together.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_reg <= '0;
        end else if (load) begin
            shreg_reg <= d;
        end else if (shift) begin
            shreg_reg <= shifted;
        end
    end
endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word when idle and
// streams it one bit per enabled clock with valid/last/done framing.
module piso_shift_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    piso_shift_tx_if.slave    bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             sout_reg, sout_next;
    logic             sout_valid_reg, sout_valid_next;
    logic             last_reg, last_next;
    logic             done_reg, done_next;
    logic             load_acc;
    logic             consume;
    logic             shreg_next_bit;
    logic             first_bit;

    assign cnt_inc   = cnt_reg + CNT_W'(1);
    assign first_bit = MSB_FIRST ? bus.in[WIDTH-1] : bus.in[0];

    piso_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .load     (load_acc),
        .shift    (consume),
        .d        (bus.in),
        .next_bit (shreg_next_bit)
    );

    // State, counter and registered framing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            sout_reg       <= 1'b0;
            sout_valid_reg <= 1'b0;
            last_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            sout_reg       <= sout_next;
            sout_valid_reg <= sout_valid_next;
            last_reg       <= last_next;
            done_reg       <= done_next;
        end
    end

    // Next-state and next-output logic; everything holds unless a load is
    // accepted or a bit is consumed. done is always a single-cycle pulse.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        sout_next       = sout_reg;
        sout_valid_next = sout_valid_reg;
        last_next       = last_reg;
        done_next       = 1'b0;
        load_acc        = 1'b0;
        consume         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.load) begin
                    load_acc        = 1'b1;
                    state_next      = SHIFT;
                    cnt_next        = '0;
                    sout_next       = first_bit;
                    sout_valid_next = 1'b1;
                    last_next       = (CNT_LAST == '0);
                end
            end
            SHIFT: begin
                if (bus.en) begin
                    consume = 1'b1;
                    if (last_reg) begin
                        state_next      = IDLE;
                        cnt_next        = '0;
                        sout_next       = 1'b0;
                        sout_valid_next = 1'b0;
                        last_next       = 1'b0;
                        done_next       = 1'b1;
                    end else begin
                        cnt_next  = cnt_inc;
                        sout_next = shreg_next_bit;
                        last_next = (cnt_inc == CNT_LAST);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ready      = (state_reg == IDLE);
    assign bus.sout       = sout_reg;
    assign bus.sout_valid = sout_valid_reg;
    assign bus.last       = last_reg;
    assign bus.done       = done_reg;
endmodule
